// File: rtl/alu_result_tx.sv
// alu_result_tx: serial response transmitter for the ALU serial protocol.
//
// Accepts one result transaction per in_valid/in_ready handshake and sends it
// on sout as 11-bit frames: start(0), type(0=DATA,1=CTL), d[7:0] MSB first,
// stop(1). Each bit is held for CLKS_PER_BIT clk cycles. A normal response is
// four DATA frames (C[31:24] .. C[7:0]) followed by a CTL frame
// {0, flags, crc3}. An error response is a single CTL frame
// {1, err_flags, err_flags, parity}.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   in_valid      transaction presented on in_*
//   in_ready      idle, a transaction can be accepted
//   in_err        send an error response (in_C / in_flags ignored)
//   in_err_flags  {ERR_DATA, ERR_CRC, ERR_OP}
//   in_C          32-bit ALU result
//   in_flags      {carry, overflow, zero, negative}
//   sout          serial output, idles high
//   busy          high while a response is being transmitted
//
// state | meaning
// IDLE  | sout high, in_ready high, waiting for in_valid
// SEND  | shifting out the frames of one response

module alu_result_tx #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_err,
    input  logic [2:0]  in_err_flags,
    input  logic [31:0] in_C,
    input  logic [3:0]  in_flags,
    output logic        sout,
    output logic        busy
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLKS_PER_BIT - 1);

    state_t      state, state_nx;
    logic [3:0]  div_cnt, div_nx;
    logic [3:0]  bit_idx, bit_nx;
    logic [2:0]  frame_idx, frame_nx;
    logic [10:0] shreg, shreg_nx;
    logic [10:0] first_frame, next_frame;
    logic [2:0]  frame_inc, last_frame;

    // C[31:24] goes out in the first frame straight from in_C, so only the
    // lower three bytes need holding.
    logic        err_q;
    logic [23:0] c_q;
    logic [3:0]  flags_q;
    logic [2:0]  crc_q;

    logic accept;
    assign accept = in_valid && (state == IDLE);

    // x^3+x+1, init 000, MSB first.
    function automatic logic [2:0] crc3(input logic [36:0] d);
        logic [2:0] r;
        logic       fb;
        r = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = r[2] ^ d[i];
            r  = {r[1:0], 1'b0} ^ {1'b0, fb, fb};
        end
        return r;
    endfunction

    function automatic logic [10:0] mk_frame(input logic typ, input logic [7:0] d);
        return {1'b0, typ, d, 1'b1};
    endfunction

    function automatic logic [7:0] err_byte(input logic [2:0] ef);
        logic [6:0] b;
        b = {1'b1, ef, ef};
        return {b, ^b};
    endfunction

    always_comb begin
        first_frame = in_err ? mk_frame(1'b1, err_byte(in_err_flags))
                             : mk_frame(1'b0, in_C[31:24]);
        frame_inc   = frame_idx + 3'd1;
        last_frame  = err_q ? 3'd0 : 3'd4;
        case (frame_inc)
            3'd1:    next_frame = mk_frame(1'b0, c_q[23:16]);
            3'd2:    next_frame = mk_frame(1'b0, c_q[15:8]);
            3'd3:    next_frame = mk_frame(1'b0, c_q[7:0]);
            default: next_frame = mk_frame(1'b1, {1'b0, flags_q, crc_q});
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_idx   <= '0;
            frame_idx <= '0;
            shreg     <= '1;
        end else begin
            state     <= state_nx;
            div_cnt   <= div_nx;
            bit_idx   <= bit_nx;
            frame_idx <= frame_nx;
            shreg     <= shreg_nx;
        end
    end

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_idx;
        frame_nx = frame_idx;
        shreg_nx = shreg;
        sout     = 1'b1;
        busy     = 1'b0;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = SEND;
                    div_nx   = '0;
                    bit_nx   = '0;
                    frame_nx = '0;
                    shreg_nx = first_frame;
                end
            end
            SEND: begin
                sout = shreg[10];
                busy = 1'b1;
                if (div_cnt == DIV_LAST) begin
                    div_nx = '0;
                    if (bit_idx == 4'd10) begin
                        bit_nx = '0;
                        if (frame_idx == last_frame) begin
                            state_nx = IDLE;
                            frame_nx = '0;
                            shreg_nx = '1;
                        end else begin
                            frame_nx = frame_inc;
                            shreg_nx = next_frame;
                        end
                    end else begin
                        bit_nx   = bit_idx + 4'd1;
                        shreg_nx = {shreg[9:0], 1'b1};
                    end
                end else begin
                    div_nx = div_cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            c_q     <= '0;
            flags_q <= '0;
            crc_q   <= '0;
        end else if (accept) begin
            err_q   <= in_err;
            c_q     <= in_C[23:0];
            flags_q <= in_flags;
            crc_q   <= crc3({in_C, 1'b0, in_flags});
        end
    end

endmodule

// File: tb/tb_alu_result_tx.sv
module tb_alu_result_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid1, in_ready1, in_err1, sout1, busy1;
    logic [2:0]  in_err_flags1;
    logic [31:0] in_C1;
    logic [3:0]  in_flags1;

    logic        in_valid4, in_ready4, in_err4, sout4, busy4;
    logic [2:0]  in_err_flags4;
    logic [31:0] in_C4;
    logic [3:0]  in_flags4;

    alu_result_tx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_err(in_err1), .in_err_flags(in_err_flags1), .in_C(in_C1),
        .in_flags(in_flags1), .sout(sout1), .busy(busy1));

    alu_result_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_err(in_err4), .in_err_flags(in_err_flags4), .in_C(in_C4),
        .in_flags(in_flags4), .sout(sout4), .busy(busy4));

    int checks = 0;
    int failures = 0;
    logic exp_bits[$];

    typedef struct {
        logic        err;
        logic [2:0]  ef;
        logic [31:0] c;
        logic [3:0]  f;
        logic [7:0]  ctl;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: remainder of {C,0,flags}*x^3 modulo x^3+x+1 by long division.
    function automatic logic [2:0] crc_model(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] v;
        v = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (v[i]) v = v ^ (40'hB << (i - 3));
        return v[2:0];
    endfunction

    function automatic logic [7:0] err_ctl_model(input logic [2:0] ef);
        logic [7:0] b;
        b = 8'h80 | (8'(ef) << 4) | (8'(ef) << 1);
        b[0] = ($countones(b[7:1]) % 2) == 1;
        return b;
    endfunction

    function automatic void push_frame(input logic typ, input logic [7:0] d);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(typ);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
        exp_bits.push_back(1'b1);
    endfunction

    function automatic void push_normal(input logic [31:0] c, input logic [7:0] ctl);
        push_frame(1'b0, c[31:24]);
        push_frame(1'b0, c[23:16]);
        push_frame(1'b0, c[15:8]);
        push_frame(1'b0, c[7:0]);
        push_frame(1'b1, ctl);
    endfunction

    function automatic void build_model(input logic err, input logic [2:0] ef,
                                        input logic [31:0] c, input logic [3:0] f);
        if (err) push_frame(1'b1, err_ctl_model(ef));
        else     push_normal(c, {1'b0, f, crc_model(c, f)});
    endfunction

    task automatic wait_ready1(input string name);
        int n;
        n = 0;
        while (!in_ready1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready_timeout"}, 32'(in_ready1), 32'd1);
    endtask

    task automatic drive1(input logic err, input logic [2:0] ef,
                          input logic [31:0] c, input logic [3:0] f);
        in_valid1 = 1'b1;
        in_err1 = err;
        in_err_flags1 = ef;
        in_C1 = c;
        in_flags1 = f;
    endtask

    // Sends one transaction on the CLKS_PER_BIT=1 instance and compares sout
    // against exp_bits, then checks the return to idle.
    task automatic run1(input logic err, input logic [2:0] ef, input logic [31:0] c,
                        input logic [3:0] f, input bit scramble, input string name);
        int n;
        n = exp_bits.size();
        wait_ready1(name);
        drive1(err, ef, c, f);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        if (scramble) begin
            in_C1 = $urandom;
            in_flags1 = 4'($urandom);
            in_err1 = ~err;
            in_err_flags1 = 3'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) chk({name, "_ready_low"}, 32'(in_ready1), 32'd0);
            chk($sformatf("%s_bit%0d", name, i), 32'(sout1), 32'(exp_bits[i]));
            chk($sformatf("%s_busy%0d", name, i), 32'(busy1), 32'd1);
        end
        @(negedge clk);
        chk({name, "_end_sout"}, 32'(sout1), 32'd1);
        chk({name, "_end_busy"}, 32'(busy1), 32'd0);
        chk({name, "_end_ready"}, 32'(in_ready1), 32'd1);
    endtask

    initial begin
        logic        r_err;
        logic [2:0]  r_ef;
        logic [31:0] r_c;
        logic [3:0]  r_f;
        int          len1, total;

        vecs[0] = '{1'b1, 3'b100, 32'h0, 4'h0, 8'hC9};
        vecs[1] = '{1'b1, 3'b010, 32'h0, 4'h0, 8'hA5};
        vecs[2] = '{1'b1, 3'b001, 32'h0, 4'h0, 8'h93};
        vecs[3] = '{1'b1, 3'b000, 32'hFFFF_FFFF, 4'hF, 8'h81};
        vecs[4] = '{1'b0, 3'b000, 32'h0, 4'b0000, 8'h00};
        vecs[5] = '{1'b0, 3'b000, 32'h0, 4'b0001, 8'h0B};
        vecs[6] = '{1'b0, 3'b000, 32'h0, 4'b0010, 8'h16};

        drive1(1'b0, 3'b0, 32'h0, 4'h0);
        in_valid1 = 1'b1;
        in_valid4 = 1'b1;
        in_err4 = 1'b0;
        in_err_flags4 = 3'b0;
        in_C4 = 32'h0;
        in_flags4 = 4'h0;

        // Reset held two cycles with in_valid high: reset must win.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sout", 32'(sout1), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ready", 32'(in_ready1), 32'd1);
        chk("rst_sout4", 32'(sout4), 32'd1);
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle_sout%0d", i), 32'(sout1), 32'd1);
            chk($sformatf("idle_busy%0d", i), 32'(busy1), 32'd0);
        end

        // Table-driven vectors with hand-derived CTL bytes.
        for (int k = 0; k < 7; k++) begin
            exp_bits.delete();
            if (vecs[k].err) push_frame(1'b1, vecs[k].ctl);
            else push_normal(vecs[k].c, vecs[k].ctl);
            run1(vecs[k].err, vecs[k].ef, vecs[k].c, vecs[k].f, 1'b0, $sformatf("vec%0d", k));
        end

        // Known C, inputs scrambled after acceptance.
        exp_bits.delete();
        build_model(1'b0, 3'b0, 32'h1234_5678, 4'b0010);
        run1(1'b0, 3'b0, 32'h1234_5678, 4'b0010, 1'b1, "c12345678");

        // Randomized transactions against the model.
        for (int k = 0; k < 20; k++) begin
            r_err = ($urandom_range(0, 3) == 0);
            r_ef = 3'($urandom);
            r_c = $urandom;
            r_f = 4'($urandom);
            exp_bits.delete();
            build_model(r_err, r_ef, r_c, r_f);
            run1(r_err, r_ef, r_c, r_f, 1'($urandom), $sformatf("rand%0d", k));
        end

        // Back-to-back with in_valid held high: one idle-high clk between.
        wait_ready1("b2b");
        r_c = $urandom;
        r_f = 4'($urandom);
        exp_bits.delete();
        build_model(1'b0, 3'b0, r_c, r_f);
        len1 = exp_bits.size();
        exp_bits.push_back(1'b1);
        build_model(1'b1, 3'b010, 32'h0, 4'h0);
        total = exp_bits.size();
        drive1(1'b0, 3'b0, r_c, r_f);
        @(posedge clk);
        #1;
        drive1(1'b1, 3'b010, 32'h0, 4'h0);
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_bit%0d", i), 32'(sout1), 32'(exp_bits[i]));
            chk($sformatf("b2b_busy%0d", i), 32'(busy1), (i == len1) ? 32'd0 : 32'd1);
            if (i == len1 + 1) in_valid1 = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_ready", 32'(in_ready1), 32'd1);
        chk("b2b_end_sout", 32'(sout1), 32'd1);

        // Reset at bit 20 of a normal response.
        wait_ready1("midrst");
        r_c = $urandom;
        r_f = 4'($urandom);
        exp_bits.delete();
        build_model(1'b0, 3'b0, r_c, r_f);
        drive1(1'b0, 3'b0, r_c, r_f);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_bit%0d", i), 32'(sout1), 32'(exp_bits[i]));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_sout", 32'(sout1), 32'd1);
        chk("midrst_ready", 32'(in_ready1), 32'd1);
        chk("midrst_busy", 32'(busy1), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_idle%0d", i), 32'(sout1), 32'd1);
            chk($sformatf("midrst_idlebusy%0d", i), 32'(busy1), 32'd0);
        end

        // CLKS_PER_BIT=4, ERR_DATA: 44-cycle frame, each bit held 4 clks.
        exp_bits.delete();
        push_frame(1'b1, 8'hC9);
        chk("cpb4_ready_start", 32'(in_ready4), 32'd1);
        in_valid4 = 1'b1;
        in_err4 = 1'b1;
        in_err_flags4 = 3'b100;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_err_flags4 = 3'b011;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            chk($sformatf("cpb4_bit%0d", i), 32'(sout4), 32'(exp_bits[i / 4]));
            chk($sformatf("cpb4_busy%0d", i), 32'(busy4), 32'd1);
        end
        @(negedge clk);
        chk("cpb4_end_busy", 32'(busy4), 32'd0);
        chk("cpb4_end_ready", 32'(in_ready4), 32'd1);
        chk("cpb4_end_sout", 32'(sout4), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_tx.md
Name: alu_result_tx

Overview:
- Serial response transmitter for the ALU serial protocol. It drives the `sout` line that the testbench BFM captures.
- Accepts one result transaction per handshake. A transaction is either a 32-bit result C with 4 flags, or an error indication.
- Serialises the transaction as 11-bit frames: a normal response is 4 DATA frames plus 1 CTL frame; an error response is a single CTL frame.
- Sits between the ALU core and the `sout` pin; it is the transmit-side counterpart of the BFM's `capture_sout`.

Parameters:
- CLKS_PER_BIT, 1, number of clk cycles each serial bit is held on sout (legal range 1..16).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  a transaction is presented on in_*.
- in_ready  output  1  block is idle and can accept a transaction.
- in_err  input  1  1 = send an error response; in_C and in_flags are ignored.
- in_err_flags  input  3  {ERR_DATA, ERR_CRC, ERR_OP}.
- in_C  input  32  ALU result.
- in_flags  input  4  {carry, overflow, zero, negative}.
- sout  output  1  serial output line; idles high.
- busy  output  1  high while a response is being transmitted.

Behaviour:
- Reset: synchronous, active-high, and overrides everything else.
  - sout=1, busy=0, in_ready=1 from the first edge with rst=1.
  - All counters cleared.
  - A reset in the middle of a frame aborts it: sout=1 after the next edge, and no partial frames resume after reset.
- Frame format, sent MSB first with no gap between frames of one response:
  - start bit 0
  - type bit (0=DATA, 1=CTL)
  - d[7] .. d[0]
  - stop bit 1
  - Each bit is held for CLKS_PER_BIT clk cycles, so one frame lasts 11*CLKS_PER_BIT cycles.
- Handshake:
  - A transaction is accepted at a rising edge where in_valid && in_ready.
  - All in_* inputs are registered at acceptance; later changes are ignored.
  - in_ready = (state == IDLE); it is deasserted from the edge after acceptance.
- Latency:
  - The start bit of the first frame appears on sout immediately after the accepting edge.
  - busy is high for exactly 55*CLKS_PER_BIT cycles (normal) or 11*CLKS_PER_BIT cycles (error).
- Completion:
  - After the last stop-bit period the state returns to IDLE, sout=1 and in_ready=1.
  - The next acceptance can occur at the earliest one clk later, so at least one idle-high clk separates responses.
- Normal response (in_err=0), in this order:
  - DATA frames carrying C[31:24], C[23:16], C[15:8], C[7:0].
  - Then a CTL frame: {1'b0, flags[3:0], crc3[2:0]}.
- CRC3:
  - Polynomial x^3+x+1, initial value 000.
  - Computed over the 37-bit vector {C, 1'b0, flags}, MSB first.
  - Must be bit-identical to the team's crc3_generate(data, 3'b000).
  - It may be computed combinationally at acceptance or serially during the DATA frames, but must be final before the CTL frame starts.
- Error response (in_err=1):
  - A single CTL frame only: {1'b1, ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP, P}.
  - P = XOR of bits [7:1].
  - in_err=1 with all in_err_flags zero still sends the frame, giving CTL=0x81.
- State machine: IDLE -> SEND -> IDLE.
  - SEND uses three counters: clk divider 0..CLKS_PER_BIT-1, bit_idx 0..10, frame_idx 0..4 (0..0 for an error response).
  - The shift register is reloaded at each frame boundary.
- Simultaneous events: rst with in_valid means reset wins and the transaction is not accepted. in_valid while busy is ignored, and the upstream block holds it.

Test Plan:
- Reset: hold rst for 2 cycles, then release → sout=1, in_ready=1, busy=0; sout stays 1 for 20 idle cycles.
- Normal response, C=0, flags=0, CLKS_PER_BIT=1 → 55 bits: four frames 0,0,00000000,1 followed by 0,1,00000000,1 (CTL=0x00); busy high for 55 cycles; in_ready high 1 cycle after the last stop bit.
- Normal response, C=0x12345678, flags=4'b0010 → DATA bytes 0x12, 0x34, 0x56, 0x78 with type bit 0; CTL bit7=0, bits[6:3]=0010, bits[2:0] equal to crc3_generate({C,1'b0,4'b0010},0); in_C changed mid-transmission has no effect on sout.
- Error responses (11 cycles each):
  - in_err=1, flags 100 → frame 0,1,0xC9,1.
  - flags 010 → 0xA5.
  - flags 001 → 0x93.
  - flags 000 → 0x81.
- Back-to-back: in_valid held high with two transactions → the second start bit follows the first response's final stop bit after exactly 1 idle-high clk.
- CLKS_PER_BIT=4 with ERR_DATA → 44-cycle frame, each bit held 4 cycles. A separate normal response at CLKS_PER_BIT=1 with rst asserted at bit 20 → sout=1 and in_ready=1 after that edge, and no further activity.
